// File: rtl/conv_window_buffer.sv
// Streams raster pixels into a K-row ring line buffer and presents zero-padded KxK windows
// one at a time on a buffer_valid/pe_ready handshake.
module conv_window_buffer #(
    parameter int pDATA_WIDTH   = 8,
    parameter int pIN_CHANNEL   = 1,
    parameter int pINPUT_WIDTH  = 28,
    parameter int pINPUT_HEIGHT = 28,
    parameter int pKERNEL_SIZE  = 3,
    parameter int pPADDING      = 1,
    parameter int pSTRIDE       = 1
) (
    input  logic                                                          clk,
    input  logic                                                          rst,
    input  logic                                                          en,
    input  logic                                                          in_valid,
    output logic                                                          in_ready,
    input  logic [pIN_CHANNEL*pDATA_WIDTH-1:0]                            in_data,
    output logic [pKERNEL_SIZE*pKERNEL_SIZE*pIN_CHANNEL*pDATA_WIDTH-1:0]  window_data,
    output logic                                                          buffer_valid,
    input  logic                                                          pe_ready,
    output logic [$clog2((pINPUT_HEIGHT+2*pPADDING-pKERNEL_SIZE)/pSTRIDE+2)-1:0] out_row,
    output logic [$clog2((pINPUT_WIDTH+2*pPADDING-pKERNEL_SIZE)/pSTRIDE+2)-1:0]  out_col,
    output logic                                                          busy,
    output logic                                                          done
);

    localparam int W      = pINPUT_WIDTH;
    localparam int H      = pINPUT_HEIGHT;
    localparam int K      = pKERNEL_SIZE;
    localparam int P      = pPADDING;
    localparam int S      = pSTRIDE;
    localparam int OUT_W  = (W + 2*P - K) / S + 1;
    localparam int OUT_H  = (H + 2*P - K) / S + 1;
    localparam int PIX_W  = pIN_CHANNEL * pDATA_WIDTH;
    localparam int ROW_W  = $clog2(OUT_H + 1);
    localparam int COL_W  = $clog2(OUT_W + 1);
    localparam int AR_W   = $clog2(H + 1);
    localparam int AC_W   = $clog2(W + 1);
    localparam int SLOT_W = $clog2(K + 1);
    localparam int MEM_AW = $clog2(K * W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;

    logic [1:0]        state;
    logic [AR_W-1:0]   acc_row;
    logic [AC_W-1:0]   acc_col;
    logic [SLOT_W-1:0] wr_slot;
    logic [ROW_W-1:0]  oy;
    logic [COL_W-1:0]  ox;
    logic [PIX_W-1:0]  line_mem [K*W];
    logic [K*K*PIX_W-1:0] next_window;

    int  win_top;
    int  win_left;
    int  keep_top;
    int  row_limit;
    int  need_rows;
    logic win_ready;

    // Rows above keep_top are no longer referenced by the current or any later window.
    assign win_top   = int'(oy) * S - P;
    assign win_left  = int'(ox) * S - P;
    assign keep_top  = (win_top > 0) ? win_top : 0;
    assign row_limit = (keep_top + K < H) ? keep_top + K : H;
    assign need_rows = ((win_top + K - 1 < H - 1) ? win_top + K - 1 : H - 1) + 1;
    assign win_ready = int'(acc_row) >= need_rows;
    assign in_ready  = (state == ST_RUN) && (int'(acc_row) < row_limit);

    // NOTE: combinational block uses blocking assignments and defaults every output first, so no latch is inferred.
    always_comb begin
        next_window = '0;
        for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
                if (win_top + ky >= 0 && win_top + ky < H && win_left + kx >= 0 && win_left + kx < W) begin
                    next_window[(ky*K + kx)*PIX_W +: PIX_W] =
                        line_mem[MEM_AW'(((win_top + ky) % K) * W + win_left + kx)];
                end
            end
        end
    end

    // NOTE: the line buffer has no reset; every location is written before it is read within a frame.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            line_mem[MEM_AW'(int'(wr_slot) * W + int'(acc_col))] <= in_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            acc_row      <= '0;
            acc_col      <= '0;
            wr_slot      <= '0;
            oy           <= '0;
            ox           <= '0;
            buffer_valid <= 1'b0;
            window_data  <= '0;
            out_row      <= '0;
            out_col      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        acc_row <= '0;
                        acc_col <= '0;
                        wr_slot <= '0;
                        oy      <= '0;
                        ox      <= '0;
                    end
                end
                ST_RUN: begin
                    if (in_valid && in_ready) begin
                        if (acc_col == AC_W'(W - 1)) begin
                            acc_col <= '0;
                            acc_row <= acc_row + 1'b1;
                            wr_slot <= (wr_slot == SLOT_W'(K - 1)) ? '0 : wr_slot + 1'b1;
                        end else begin
                            acc_col <= acc_col + 1'b1;
                        end
                    end
                    // A consumed window always leaves buffer_valid low for one cycle before the next load.
                    if (buffer_valid) begin
                        if (pe_ready) begin
                            buffer_valid <= 1'b0;
                            if (ox == COL_W'(OUT_W - 1)) begin
                                ox <= '0;
                                if (oy == ROW_W'(OUT_H - 1)) begin
                                    state <= ST_LAST;
                                    done  <= 1'b1;
                                end else begin
                                    oy <= oy + 1'b1;
                                end
                            end else begin
                                ox <= ox + 1'b1;
                            end
                        end
                    end else if (win_ready) begin
                        buffer_valid <= 1'b1;
                        window_data  <= next_window;
                        out_row      <= oy;
                        out_col      <= ox;
                    end
                end
                ST_LAST: begin
                    state       <= ST_IDLE;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    window_data <= '0;
                    out_row     <= '0;
                    out_col     <= '0;
                    acc_row     <= '0;
                    acc_col     <= '0;
                    wr_slot     <= '0;
                    oy          <= '0;
                    ox          <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench: three buffer configurations (4x4 S1, 5x5 S2, 28x28 S1) with expected windows
// queued at frame start and checked by per-instance monitors on each consumption.
module tb_conv_window_buffer;

    typedef struct packed {
        logic [4:0]  row;
        logic [4:0]  col;
        logic [71:0] data;
    } exp_t;

    logic clk;
    logic rst_ab;
    logic c_rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    // ---------------- instance A: 4x4, K=3, P=1, S=1
    logic        a_en = 0, a_pe_ready = 0, a_feed = 0;
    logic        a_in_valid, a_in_ready, a_bv, a_busy, a_done;
    logic [7:0]  a_in_data;
    logic [71:0] a_win;
    logic [2:0]  a_row, a_col;
    int          a_idx = 0, a_cons = 0, a_done_cnt = 0, a_done_edge = -1, a_last_edge = -2;
    int          a_acc8_edge = -1, a_bv_edge = -1;
    logic        a_fire = 0, a_hold = 0, a_seen_bv = 0;
    logic [77:0] a_held = '0;

    assign a_in_valid = a_feed && (a_idx < 16);
    assign a_in_data  = 8'(a_idx + 1);

    conv_window_buffer #(.pINPUT_WIDTH(4), .pINPUT_HEIGHT(4), .pSTRIDE(1)) u_a (
        .clk(clk), .rst(rst_ab), .en(a_en), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .window_data(a_win), .buffer_valid(a_bv), .pe_ready(a_pe_ready),
        .out_row(a_row), .out_col(a_col), .busy(a_busy), .done(a_done)
    );

    // ---------------- instance B: 5x5, K=3, P=1, S=2
    logic        b_en = 0, b_pe_ready = 0, b_feed = 0;
    logic        b_in_valid, b_in_ready, b_bv, b_busy, b_done;
    logic [7:0]  b_in_data;
    logic [71:0] b_win;
    logic [1:0]  b_row, b_col;
    int          b_idx = 0, b_cons = 0, b_done_cnt = 0;
    logic        b_fire = 0;

    assign b_in_valid = b_feed && (b_idx < 25);
    assign b_in_data  = 8'(b_idx + 1);

    conv_window_buffer #(.pINPUT_WIDTH(5), .pINPUT_HEIGHT(5), .pSTRIDE(2)) u_b (
        .clk(clk), .rst(rst_ab), .en(b_en), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .window_data(b_win), .buffer_valid(b_bv), .pe_ready(b_pe_ready),
        .out_row(b_row), .out_col(b_col), .busy(b_busy), .done(b_done)
    );

    // ---------------- instance C: defaults 28x28, K=3, P=1, S=1
    logic        c_en = 0, c_pe_ready = 0, c_feed = 0, c_pulse = 0;
    logic        c_in_valid, c_in_ready, c_bv, c_busy, c_done;
    logic [7:0]  c_in_data;
    logic [71:0] c_win;
    logic [4:0]  c_row, c_col, c_last_row = '0, c_last_col = '0;
    int          c_idx = 0, c_cons = 0, c_done_cnt = 0, c_ph = 0;
    logic        c_fire = 0, c_hold = 0;
    logic [81:0] c_held = '0;

    assign c_in_valid = c_feed && (c_idx < 784);
    assign c_in_data  = 8'(c_idx + 1);

    conv_window_buffer u_c (
        .clk(clk), .rst(c_rst), .en(c_en), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .window_data(c_win), .buffer_valid(c_bv), .pe_ready(c_pe_ready),
        .out_row(c_row), .out_col(c_col), .busy(c_busy), .done(c_done)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Pixel (r,c) carries r*w+c+1; out-of-frame elements are zero.
    function automatic logic [71:0] model(input int w, input int h, input int s, input int oy, input int ox);
        logic [71:0] v;
        v = '0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                int r;
                int c;
                r = oy*s - 1 + ky;
                c = ox*s - 1 + kx;
                if (r >= 0 && r < h && c >= 0 && c < w) v[(ky*3 + kx)*8 +: 8] = 8'(r*w + c + 1);
            end
        end
        return v;
    endfunction

    task automatic push_frame(input int which, input int w, input int h, input int s);
        exp_t e;
        for (int oy = 0; oy < (h - 1)/s + 1; oy++) begin
            for (int ox = 0; ox < (w - 1)/s + 1; ox++) begin
                e.row  = 5'(oy);
                e.col  = 5'(ox);
                e.data = model(w, h, s, oy, ox);
                case (which)
                    0: q_a.push_back(e);
                    1: q_b.push_back(e);
                    default: q_c.push_back(e);
                endcase
            end
        end
    endtask

    // Directed windows from the 4x4 frame replace the model entries.
    task automatic push_frame_a();
        push_frame(0, 4, 4, 1);
        q_a[0].data  = 72'h06_05_00_02_01_00_00_00_00;
        q_a[15].data = 72'h00_00_00_00_10_0f_00_0c_0b;
    endtask

    // ---------------- pixel feeders: count a pixel when in_valid && in_ready before the edge
    initial forever begin
        @(negedge clk);
        a_fire = a_in_valid && a_in_ready;
        b_fire = b_in_valid && b_in_ready;
        c_fire = c_in_valid && c_in_ready;
        if (a_fire && a_idx == 7) a_acc8_edge = cyc + 1;
        @(posedge clk);
        #1;
        if (a_fire) a_idx++;
        if (b_fire) b_idx++;
        if (c_fire) c_idx++;
    end

    // pe_ready for instance C: one cycle high every 20
    initial forever begin
        @(posedge clk);
        #1;
        if (c_pulse) begin
            c_ph       = (c_ph == 19) ? 0 : c_ph + 1;
            c_pe_ready = (c_ph == 0);
        end else begin
            c_ph       = 0;
            c_pe_ready = 0;
        end
    end

    // ---------------- monitors
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (a_bv && a_hold) check("a_stable", {a_row, a_col, a_win}, a_held);
        a_hold = a_bv && !a_pe_ready;
        a_held = {a_row, a_col, a_win};
        if (a_bv && !a_seen_bv) begin
            a_seen_bv = 1;
            a_bv_edge = cyc;
        end
        if (a_bv && a_pe_ready) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_extra_window: got row %0d col %0d, expected no window", a_row, a_col);
            end else begin
                e = q_a.pop_front();
                check("a_row", a_row, e.row);
                check("a_col", a_col, e.col);
                check("a_data", a_win, e.data);
            end
            a_cons++;
            a_last_edge = cyc + 1;
        end
        if (a_done) begin
            a_done_cnt++;
            a_done_edge = cyc;
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (b_bv && b_pe_ready) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_extra_window: got row %0d col %0d, expected no window", b_row, b_col);
            end else begin
                e = q_b.pop_front();
                check("b_row", b_row, e.row);
                check("b_col", b_col, e.col);
                check("b_data", b_win, e.data);
            end
            b_cons++;
        end
        if (b_done) b_done_cnt++;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (c_bv && c_hold) check("c_stable", {c_row, c_col, c_win}, c_held);
        c_hold = c_bv && !c_pe_ready;
        c_held = {c_row, c_col, c_win};
        if (c_bv && c_pe_ready) begin
            if (q_c.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL c_extra_window: got row %0d col %0d, expected no window", c_row, c_col);
            end else begin
                e = q_c.pop_front();
                check("c_row", c_row, e.row);
                check("c_col", c_col, e.col);
                check("c_data", c_win, e.data);
            end
            c_cons++;
            c_last_row = c_row;
            c_last_col = c_col;
        end
        if (c_done) c_done_cnt++;
    end

    // ---------------- directed sequence
    initial begin
        rst_ab = 1;
        c_rst  = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("a_reset_outputs", {a_in_ready, a_bv, a_busy, a_done, a_row, a_col, a_win}, '0);
        check("c_reset_outputs", {c_in_ready, c_bv, c_busy, c_done, c_row, c_col, c_win}, '0);
        @(posedge clk);
        #1;
        rst_ab = 0;
        c_rst  = 0;

        // A frame 1: free-running input and consumer
        push_frame_a();
        a_pe_ready = 1;
        a_feed     = 1;
        @(posedge clk); #1 a_en = 1;
        @(posedge clk); #1 a_en = 0;
        @(negedge clk);
        check("a_busy_after_en", a_busy, 1);
        for (int i = 0; i < 400 && a_done_cnt < 1; i++) @(posedge clk);
        check("a1_done_seen", a_done_cnt, 1);
        repeat (3) @(negedge clk);
        check("a1_done_once", a_done_cnt, 1);
        check("a1_done_after_last", a_done_edge, a_last_edge);
        check("a1_first_bv_latency", a_bv_edge, a_acc8_edge + 1);
        check("a1_windows", a_cons, 16);
        check("a1_queue_empty", q_a.size(), 0);
        check("a1_idle_outputs", {a_busy, a_bv, a_in_ready, a_done}, '0);

        // A frame 2: consumer stalled, input always offered
        @(posedge clk);
        #1;
        a_feed     = 0;
        a_pe_ready = 0;
        a_idx      = 0;
        a_seen_bv  = 0;
        push_frame_a();
        a_feed = 1;
        @(posedge clk); #1 a_en = 1;
        @(posedge clk); #1 a_en = 0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("a2_pixels_accepted", a_idx, 12);
        check("a2_in_ready_low", a_in_ready, 0);
        check("a2_bv_held", a_bv, 1);
        check("a2_pos_held", {a_row, a_col}, 6'd0);
        @(posedge clk); #1 a_pe_ready = 1;
        for (int i = 0; i < 400 && a_done_cnt < 2; i++) @(posedge clk);
        check("a2_done_seen", a_done_cnt, 2);
        check("a2_windows", a_cons, 32);

        // B: stride 2
        push_frame(1, 5, 5, 2);
        q_b[4].data = 72'h13_12_11_0e_0d_0c_09_08_07;
        b_pe_ready = 1;
        b_feed     = 1;
        @(posedge clk); #1 b_en = 1;
        @(posedge clk); #1 b_en = 0;
        for (int i = 0; i < 400 && b_done_cnt < 1; i++) @(posedge clk);
        check("b_done_seen", b_done_cnt, 1);
        check("b_windows", b_cons, 9);
        check("b_queue_empty", q_b.size(), 0);

        // C: pulsing consumer, reset after 100 windows, then a full frame
        push_frame(2, 28, 28, 1);
        c_feed  = 1;
        c_pulse = 1;
        @(posedge clk); #1 c_en = 1;
        @(posedge clk); #1 c_en = 0;
        for (int i = 0; i < 5000 && c_cons < 100; i++) @(posedge clk);
        check("c_100_windows", c_cons, 100);
        #1;
        c_rst   = 1;
        c_feed  = 0;
        c_pulse = 0;
        @(posedge clk);
        @(negedge clk);
        check("c_midframe_reset", {c_in_ready, c_bv, c_busy, c_done, c_row, c_col, c_win}, '0);
        @(posedge clk);
        #1;
        c_rst = 0;
        c_idx = 0;
        c_cons = 0;
        q_c.delete();
        push_frame(2, 28, 28, 1);
        c_feed  = 1;
        c_pulse = 1;
        @(posedge clk); #1 c_en = 1;
        @(posedge clk); #1 c_en = 0;
        for (int i = 0; i < 20000 && c_done_cnt < 1; i++) @(posedge clk);
        check("c_done_seen", c_done_cnt, 1);
        check("c_windows", c_cons, 784);
        check("c_last_pos", {c_last_row, c_last_col}, {5'd27, 5'd27});
        check("c_queue_empty", q_c.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
